conware_gen_scheduler: RTL and testbench

Sequencer for the Game-of-Life pipeline. It loads a seed board and hands each board to the color-conversion/AXIS output stage over a valid/ready handshake. It then waits a programmable frame period, has the cell-update engine compute the next generation, and repeats until a generation limit or a stop request. It sits between the register interface (start/stop/limits), the conware compute engine and the buffer-to-AXIS converter, and owns the only copy of the current board.

---
 rtl/conware_gen_scheduler.sv | 142 ++++++++++++++
 tb/tb_conware_gen_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conware_gen_scheduler.sv
// Game-of-Life generation sequencer: loads a seed board, offers each board to the
// output stage over valid/ready, waits a frame period, then steps the engine once.
module conware_gen_scheduler #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HEIGHT = 4,
  parameter int unsigned CWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [CWIDTH-1:0]         gen_limit,
  input  logic [CWIDTH-1:0]         frame_period,
  input  logic [WIDTH*HEIGHT-1:0]   seed_data,
  output logic [WIDTH*HEIGHT-1:0]   eng_board_in,
  output logic                      eng_start,
  input  logic                      eng_done,
  input  logic [WIDTH*HEIGHT-1:0]   eng_board_out,
  output logic [WIDTH*HEIGHT-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [CWIDTH-1:0]         gen_count,
  output logic                      done
);

  localparam int unsigned CELLS = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_HOLD,
    S_COMPUTE
  } state_e;

  state_e             state_q, state_d;
  logic [CELLS-1:0]   board_q, board_d;
  logic [CWIDTH-1:0]  gen_count_q, gen_count_d;
  logic [CWIDTH-1:0]  period_q, period_d;
  logic               eng_start_q, eng_start_d;
  logic               done_q, done_d;
  logic               stop_seen_q, stop_seen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      board_q     <= '0;
      gen_count_q <= '0;
      period_q    <= '0;
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      gen_count_q <= gen_count_d;
      period_q    <= period_d;
      eng_start_q <= eng_start_d;
      done_q      <= done_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    gen_count_d = gen_count_q;
    period_d    = period_q;
    eng_start_d = 1'b0;
    done_d      = 1'b0;
    stop_seen_d = stop_seen_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        board_d     = seed_data;
        gen_count_d = '0;
        state_d     = S_EMIT;
      end

      S_EMIT: begin
        if (out_ready) begin
          if (stop || ((gen_limit != '0) && (gen_count_q == gen_limit))) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_HOLD;
            period_d = (frame_period == '0) ? CWIDTH'(1) : frame_period;
          end
        end
      end

      S_HOLD: begin
        period_d = period_q - CWIDTH'(1);
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (period_q == CWIDTH'(1)) begin
          state_d     = S_COMPUTE;
          eng_start_d = 1'b1;
          stop_seen_d = 1'b0;
        end
      end

      // A stop here is latched and honoured only once the engine finishes.
      S_COMPUTE: begin
        if (stop) begin
          stop_seen_d = 1'b1;
        end
        if (eng_done) begin
          board_d     = eng_board_out;
          gen_count_d = gen_count_q + CWIDTH'(1);
          if (stop_seen_q || stop) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_EMIT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign eng_board_in = board_q;
  assign out_data     = board_q;
  assign out_valid    = (state_q == S_EMIT);
  assign busy         = (state_q != S_IDLE);
  assign eng_start    = eng_start_q;
  assign gen_count    = gen_count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conware_gen_scheduler.sv
// Scoreboard bench for conware_gen_scheduler with a behavioural engine and random sink.
module tb_conware_gen_scheduler;

  localparam int unsigned N  = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] gen_limit = '0;
  logic [CW-1:0] frame_period = '0;
  logic [N-1:0]  seed_data = '0;
  logic [N-1:0]  eng_board_in;
  logic          eng_start;
  logic          eng_done = 1'b0;
  logic [N-1:0]  eng_board_out = '0;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] gen_count;
  logic          done;

  conware_gen_scheduler #(.WIDTH(4), .HEIGHT(4), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .gen_limit(gen_limit), .frame_period(frame_period), .seed_data(seed_data),
    .eng_board_in(eng_board_in), .eng_start(eng_start), .eng_done(eng_done),
    .eng_board_out(eng_board_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .gen_count(gen_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [CW-1:0] gen;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      mon_f;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned hs_cyc = 0;
  int          exp_gap = 2;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          eng_mode = 0;
  int          eng_lat = 2;
  bit          rdy_force = 1'b1;
  bit          rdy_val = 1'b1;
  int          rdy_pct = 100;
  bit          pend = 1'b0;
  logic [N-1:0] pend_data = '0;

  // Next-generation rule used by the engine stand-in; the scheduler just relays it.
  function automatic logic [N-1:0] next_board(input logic [N-1:0] b, input int mode);
    if (mode == 0) return ~b;
    return {b[N-2:0], b[N-1]} ^ 16'hA5C3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine stand-in: answers each eng_start after eng_lat cycles.
  initial begin : engine
    logic [N-1:0] b;
    forever begin
      @(negedge clk);
      if (eng_start && !rst) begin
        b = eng_board_in;
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_board_out = next_board(b, eng_mode);
        eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  initial begin : sink
    forever begin
      @(posedge clk);
      #2;
      if (rdy_force) out_ready = rdy_val;
      else out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: frame scoreboard, hold-stability, done/eng_start bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(pend_data));
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 64'(busy), 64'd0);
      end
      if (eng_start) begin
        start_cnt++;
        chk("start_gap", 64'(cyc - hs_cyc), 64'(exp_gap));
        chk("start_no_valid", 64'(out_valid), 64'd0);
      end
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %h gen %0d expected no frame", out_data, gen_count);
        end else begin
          mon_f = exp_q.pop_front();
          chk("frame_data", 64'(out_data), 64'(mon_f.data));
          chk("frame_gen", 64'(gen_count), 64'(mon_f.gen));
        end
      end
      pend = out_valid && !out_ready;
      pend_data = out_data;
    end
  end

  task automatic kick(input logic [N-1:0] seed, input int lim, input int p);
    seed_data    = seed;
    gen_limit    = CW'(lim);
    frame_period = CW'(p);
    exp_gap      = (p == 0) ? 2 : p + 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_sig(input string name, input int which, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((which == 0 && eng_start) || (which == 1 && out_valid && out_ready) ||
          (which == 2 && out_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic push_frames(input logic [N-1:0] seed, input int cnt, input int mode,
                             output logic [N-1:0] last);
    logic [N-1:0] b = seed;
    last = seed;
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back(frame_t'{data: b, gen: CW'(k)});
      last = b;
      b = next_board(b, mode);
    end
  endtask

  task automatic run_lim(input logic [N-1:0] seed, input int lim, input int p,
                         input int mode, input int lat);
    logic [N-1:0] last;
    int d0;
    eng_mode = mode;
    eng_lat  = lat;
    push_frames(seed, lim + 1, mode, last);
    d0 = done_cnt;
    kick(seed, lim, p);
    wait_done(4000);
    @(posedge clk); #1;
    chk("run_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("run_gen", 64'(gen_count), 64'(lim));
    chk("run_board", 64'(out_data), 64'(last));
    chk("run_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0] last;
    int d0, s0, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_gen", 64'(gen_count), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);

    // Seed 000F, inverting engine, 2 generations, period 3.
    rdy_force = 1'b1; rdy_val = 1'b1;
    run_lim(16'h000F, 2, 3, 0, 2);

    // Backpressure: sink stalls the seed frame for 10 cycles.
    rdy_val = 1'b0;
    eng_mode = 0; eng_lat = 1;
    push_frames(16'h1234, 2, 0, last);
    d0 = done_cnt;
    kick(16'h1234, 1, 0);
    wait_sig("bp_valid_timeout", 2, 50);
    s0 = start_cnt;
    chk("bp_data", 64'(out_data), 64'h1234);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'h1234);
    end
    @(posedge clk); #1 rdy_val = 1'b1;
    chk("bp_no_start", 64'(start_cnt - s0), 64'd0);
    wait_done(200);
    @(posedge clk); #1;
    chk("bp_gen", 64'(gen_count), 64'd1);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Stop during a long HOLD.
    push_frames(16'hBEEF, 1, 0, last);
    kick(16'hBEEF, 0, 100);
    wait_sig("hold_hs_timeout", 1, 50);
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    s0 = start_cnt;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("hold_stop_done", 64'(done), 64'd1);
    chk("hold_stop_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("hold_stop_no_start", 64'(start_cnt - s0), 64'd0);
    chk("hold_stop_gen", 64'(gen_count), 64'd0);

    // Stop during COMPUTE: engine completes, new board kept, not emitted.
    eng_mode = 1; eng_lat = 4;
    push_frames(16'h0F0F, 1, 1, last);
    d0 = done_cnt;
    kick(16'h0F0F, 0, 1);
    wait_sig("comp_start_timeout", 0, 50);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(50);
    @(posedge clk); #1;
    chk("comp_stop_gen", 64'(gen_count), 64'd1);
    chk("comp_stop_board", 64'(out_data), 64'(next_board(16'h0F0F, 1)));
    chk("comp_stop_valid", 64'(out_valid), 64'd0);
    chk("comp_stop_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("comp_stop_q_empty", 64'(exp_q.size()), 64'd0);

    // Start with stop both high stays in IDLE.
    d0 = done_cnt;
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("startstop_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    chk("startstop_done", 64'(done_cnt - d0), 64'd0);

    // Free run: gen_limit 0, period 0, 50 generations after the seed.
    eng_mode = 1; eng_lat = 1;
    push_frames(16'h8001, 51, 1, last);
    d0 = done_cnt;
    kick(16'h8001, 0, 0);
    n = 0;
    for (int i = 0; i < 2000 && n < 51; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
    end
    chk("free_frames", 64'(n), 64'd51);
    @(posedge clk); #1 stop = 1'b1;
    chk("free_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("free_stop_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("free_gen", 64'(gen_count), 64'd50);
    chk("free_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of COMPUTE.
    eng_mode = 0; eng_lat = 4;
    push_frames(16'h3C3C, 1, 0, last);
    kick(16'h3C3C, 3, 1);
    wait_sig("rst_start_timeout", 0, 50);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_eng_start", 64'(eng_start), 64'd0);
    chk("arst_gen", 64'(gen_count), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    run_lim(16'hC001, 1, 2, 0, 1);

    // Randomised runs with a random sink.
    rdy_force = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rdy_pct = int'($urandom_range(100, 30));
      run_lim(N'($urandom), int'($urandom_range(5, 1)), int'($urandom_range(3, 0)),
              int'($urandom_range(1, 0)), int'($urandom_range(3, 1)));
      repeat (2) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
